// File: rtl/pipeline_reg_if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Falling-edge state; in_ready is registered and never sees out_ready combinationally.
module pipeline_reg_if_id_skid #(
  parameter int             N           = 32,
  parameter logic [N-1:0]   VALOR_RESET = '0,
  parameter logic [N-1:0]   NOP         = 32'h00000013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] PCInput,
  input  logic [N-1:0] PCPlus4Input,
  input  logic [N-1:0] InstructionInput,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] PCOutput,
  output logic [N-1:0] PCPlus4Output,
  output logic [N-1:0] InstructionOutput
);

  logic         r_main_valid;
  logic [N-1:0] r_main_pc;
  logic [N-1:0] r_main_pc4;
  logic [N-1:0] r_main_ins;
  logic         r_skid_valid;
  logic [N-1:0] r_skid_pc;
  logic [N-1:0] r_skid_pc4;
  logic [N-1:0] r_skid_ins;
  logic         r_in_ready;

  logic         w_main_valid;
  logic [N-1:0] w_main_pc;
  logic [N-1:0] w_main_pc4;
  logic [N-1:0] w_main_ins;
  logic         w_skid_valid;
  logic [N-1:0] w_skid_pc;
  logic [N-1:0] w_skid_pc4;
  logic [N-1:0] w_skid_ins;

  logic w_accept;
  logic w_consume;
  logic w_main_free;

  assign w_accept    = in_valid & r_in_ready;
  assign w_consume   = r_main_valid & out_ready;
  assign w_main_free = ~r_main_valid | w_consume;

  always_comb begin
    w_main_valid = r_main_valid;
    w_main_pc    = r_main_pc;
    w_main_pc4   = r_main_pc4;
    w_main_ins   = r_main_ins;
    w_skid_valid = r_skid_valid;
    w_skid_pc    = r_skid_pc;
    w_skid_pc4   = r_skid_pc4;
    w_skid_ins   = r_skid_ins;
    if (flush) begin
      // Skid data is left as-is; its valid bit is what matters.
      w_main_valid = 1'b0;
      w_main_pc    = VALOR_RESET;
      w_main_pc4   = VALOR_RESET;
      w_main_ins   = NOP;
      w_skid_valid = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        w_main_valid = 1'b1;
        w_main_pc    = r_skid_pc;
        w_main_pc4   = r_skid_pc4;
        w_main_ins   = r_skid_ins;
        w_skid_valid = w_accept;
        if (w_accept) begin
          w_skid_pc  = PCInput;
          w_skid_pc4 = PCPlus4Input;
          w_skid_ins = InstructionInput;
        end
      end else if (w_accept) begin
        w_main_valid = 1'b1;
        w_main_pc    = PCInput;
        w_main_pc4   = PCPlus4Input;
        w_main_ins   = InstructionInput;
      end else begin
        w_main_valid = 1'b0;
        w_main_pc    = VALOR_RESET;
        w_main_pc4   = VALOR_RESET;
        w_main_ins   = NOP;
      end
    end else if (w_accept) begin
      w_skid_valid = 1'b1;
      w_skid_pc    = PCInput;
      w_skid_pc4   = PCPlus4Input;
      w_skid_ins   = InstructionInput;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= VALOR_RESET;
      r_main_pc4   <= VALOR_RESET;
      r_main_ins   <= NOP;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= VALOR_RESET;
      r_skid_pc4   <= VALOR_RESET;
      r_skid_ins   <= NOP;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid;
      r_main_pc    <= w_main_pc;
      r_main_pc4   <= w_main_pc4;
      r_main_ins   <= w_main_ins;
      r_skid_valid <= w_skid_valid;
      r_skid_pc    <= w_skid_pc;
      r_skid_pc4   <= w_skid_pc4;
      r_skid_ins   <= w_skid_ins;
      r_in_ready   <= ~w_skid_valid;
    end
  end

  assign in_ready          = r_in_ready;
  assign out_valid         = r_main_valid;
  assign PCOutput          = r_main_pc;
  assign PCPlus4Output     = r_main_pc4;
  assign InstructionOutput = r_main_ins;

endmodule

// File: tb/tb_pipeline_reg_if_id_skid.sv
// Scoreboard bench for the IF/ID skid register.
// Driver pushes accepted entries; a posedge monitor pops on every consume.
module tb_pipeline_reg_if_id_skid;

  localparam logic [31:0] NOPV = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] PCInput;
  logic [31:0] PCPlus4Input;
  logic [31:0] InstructionInput;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] PCOutput;
  logic [31:0] PCPlus4Output;
  logic [31:0] InstructionOutput;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];
  int   n_chk;
  int   n_fail;
  int   n_out;
  bit   started;

  pipeline_reg_if_id_skid dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .PCInput          (PCInput),
    .PCPlus4Input     (PCPlus4Input),
    .InstructionInput (InstructionInput),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .PCOutput         (PCOutput),
    .PCPlus4Output    (PCPlus4Output),
    .InstructionOutput(InstructionOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs and state seen here are what the next falling edge uses.
  always @(posedge clk) begin
    if (started && reset === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (out_ready === 1'b1) begin
          n_out++;
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got pc %h want none", PCOutput);
          end else begin
            ent_t e;
            e = q.pop_front();
            chk("out_pc", PCOutput, e.pc);
            chk("out_pc4", PCPlus4Output, e.pc4);
            chk("out_ins", InstructionOutput, e.ins);
          end
        end
      end else begin
        chk("idle_ins", InstructionOutput, NOPV);
        chk("idle_pc", PCOutput, 32'h0);
        chk("idle_valid", {31'b0, out_valid}, 32'h0);
      end
    end
  end

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic rst);
    ent_t e;
    in_valid         = v;
    PCInput          = pc;
    PCPlus4Input     = pc + 32'd4;
    InstructionInput = ins;
    out_ready        = ordy;
    flush            = fl;
    reset            = rst;
    @(posedge clk);
    #1;
    if (!rst || fl) begin
      q.delete();
    end else if (v && in_ready === 1'b1) begin
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
      e.ins = ins;
      q.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'hDEAD0000, 32'hDEADBEEF, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    int base;
    n_chk   = 0;
    n_fail  = 0;
    n_out   = 0;
    started = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    PCInput = '0; PCPlus4Input = '0; InstructionInput = '0;
    @(negedge clk);
    #1;
    step(1'b1, 32'h900, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h904, 32'h2, 1'b1, 1'b1, 1'b0);
    started = 1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_pc", PCOutput, 32'h0);
    chk("rst_pc4", PCPlus4Output, 32'h0);
    chk("rst_ins", InstructionOutput, NOPV);

    // Single transfer, one-edge latency
    step(1'b1, 32'h100, 32'h00A00093, 1'b1, 1'b0, 1'b1);
    chk("t1_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_pc", PCOutput, 32'h100);
    chk("t1_pc4", PCPlus4Output, 32'h104);
    chk("t1_ins", InstructionOutput, 32'h00A00093);
    idle(1'b1);
    chk("t1_drain_valid", {31'b0, out_valid}, 32'h0);
    chk("t1_drain_ins", InstructionOutput, NOPV);

    // Stall: two accepted, third held off
    step(1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 1'b1);
    chk("st_ready1", {31'b0, in_ready}, 32'h1);
    step(1'b1, 32'h104, 32'h22, 1'b0, 1'b0, 1'b1);
    chk("st_ready2", {31'b0, in_ready}, 32'h0);
    step(1'b1, 32'h108, 32'h33, 1'b0, 1'b0, 1'b1);
    chk("st_hold_pc", PCOutput, 32'h100);
    chk("st_hold_ready", {31'b0, in_ready}, 32'h0);
    step(1'b1, 32'h108, 32'h33, 1'b1, 1'b0, 1'b1);
    chk("st_rel_pc", PCOutput, 32'h104);
    chk("st_rel_ready", {31'b0, in_ready}, 32'h1);
    step(1'b1, 32'h108, 32'h33, 1'b1, 1'b0, 1'b1);
    chk("st_third_pc", PCOutput, 32'h108);
    chk("st_third_valid", {31'b0, out_valid}, 32'h1);
    idle(1'b1);
    chk("st_empty", {31'b0, out_valid}, 32'h0);

    // Streaming at full rate
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1, 1'b0, 1'b1);
      chk("str_ready", {31'b0, in_ready}, 32'h1);
      chk("str_pc", PCOutput, 32'h200 + 32'(4 * i));
    end
    idle(1'b1);
    chk("str_count", 32'(n_out - base), 32'd16);

    // Flush with both entries full; offered entry dropped
    step(1'b1, 32'h300, 32'h44, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h304, 32'h55, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h308, 32'h66, 1'b0, 1'b1, 1'b1);
    chk("fl_valid", {31'b0, out_valid}, 32'h0);
    chk("fl_ready", {31'b0, in_ready}, 32'h1);
    chk("fl_ins", InstructionOutput, NOPV);
    chk("fl_pc", PCOutput, 32'h0);
    idle(1'b1);
    idle(1'b1);
    // Flush while ready: accepted entry dropped, coincident consume counted
    step(1'b1, 32'h400, 32'h77, 1'b0, 1'b0, 1'b1);
    base = n_out;
    step(1'b1, 32'h404, 32'h88, 1'b1, 1'b1, 1'b1);
    chk("fl2_consumed", 32'(n_out - base), 32'd1);
    chk("fl2_valid", {31'b0, out_valid}, 32'h0);
    idle(1'b1);
    chk("fl2_nothing", {31'b0, out_valid}, 32'h0);

    // Reset while skid full and input offered
    step(1'b1, 32'h500, 32'h99, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h504, 32'hAA, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h508, 32'hBB, 1'b0, 1'b0, 1'b0);
    chk("mr_valid", {31'b0, out_valid}, 32'h0);
    chk("mr_ready", {31'b0, in_ready}, 32'h1);
    chk("mr_pc4", PCPlus4Output, 32'h0);
    chk("mr_ins", InstructionOutput, NOPV);
    idle(1'b1);
    idle(1'b1);
    chk("mr_after", {31'b0, out_valid}, 32'h0);

    // Randomised traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      logic        v, r, f;
      logic [31:0] pc;
      v  = 1'($urandom_range(0, 3) != 0);
      r  = 1'($urandom_range(0, 2) != 0);
      f  = 1'($urandom_range(0, 40) == 0);
      pc = $urandom & 32'hFFFF_FFFC;
      step(v, pc, $urandom, r, f, 1'b1);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("final_queue", 32'(q.size()), 32'd0);
    chk("final_valid", {31'b0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
